regfile_port_arb: RTL and testbench
===================================

# regfile_port_arb

Arbiter and sequencer in front of the 32 x 32-bit register file. The register file accepts one operation per cycle, either a two-operand read or a single write. This block shares that port between NUM_RD read requesters and one writeback requester, and also runs clear operations. It issues exactly one register-file operation per cycle and routes the registered read data back to the client that was granted.

## Interface
Parameters:
- NUM_RD, 2: number of read requesters, ≥1
- WR_STREAK_MAX, 4: maximum consecutive write grants while any read is pending

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_req_valid  in  NUM_RD  read request per client
- rd_req_ready  out  NUM_RD  one-hot grant; handshake completes when valid&ready
- rd_rs1, rd_rs2  in  NUM_RD*5  flattened source addresses, client i at [5i+4:5i]
- rsp_valid  out  NUM_RD  one-hot; read data valid for client i
- rsp_data1, rsp_data2  out  32  shared read data
- wr_valid  in  1  writeback request
- wr_ready  out  1  writeback grant
- wr_rd  in  5  destination address
- wr_data  in  32  write data
- clr_valid  in  1  clear-all request
- clr_ready  out  1  clear grant
- rf_en  out  1  register file enable
- rf_reset  out  1  register file clear
- rf_read_en, rf_write_en  out  1  register file read/write strobes
- rf_rs1, rf_rs2, rf_rd  out  5  register file addresses
- rf_data_in  out  32  register file write data
- rf_out1, rf_out2  in  32  register file read outputs

## Operation
- Priority per cycle: clear > (write vs read, decided by the streak rule) > idle. Exactly one grant is asserted per cycle.
- Clear: clr_ready=1 and rf_reset=1 for one cycle. rf_read_en and rf_write_en are 0 in that cycle.
- Write: wr_ready=1, rf_rd=wr_rd, rf_data_in=wr_data, rf_write_en=1.
  - When wr_rd==0, the handshake completes but rf_write_en=0, so x0 is never written.
- Read: the round-robin winner i gets rd_req_ready[i]=1, rf_rs1/rf_rs2 come from client i, and rf_read_en=1.
  - The rr pointer advances to i+1 (mod NUM_RD) only on a read grant.
  - On any read grant, the address-0 operand is forced to 0 on rsp_data in the response cycle.
- Streak counter (width clog2(WR_STREAK_MAX+1)):
  - Increments on each write grant while any rd_req_valid is set.
  - Clears on a read grant, or when no read is pending.
  - While the counter equals WR_STREAK_MAX, reads beat writes.
  - Otherwise writes beat reads.
- Response pipeline register holds the granted id and a valid bit. In the cycle after a read grant:
  - rsp_valid[id]=1.
  - rsp_data1/rsp_data2 = rf_out1/rf_out2, combinational pass-through.
- rf_en is tied to 1.
- rf_reset = reset | clear grant.
- Requests are combinational in, grants are combinational out. Clients must hold the request until the grant.

## Timing
- Read latency: grant in cycle N, rsp_valid in N+1. Back-to-back reads are sustained at 1 per cycle, so responses from consecutive grants occupy N+1, N+2, and so on.
- Write grant in N, then a read granted in N+1 returns the new value. The register file has updated at the end of N, so no bypass is needed.
- Clear in N: a read granted in N+1 returns 0. A read granted in N-1 still gets its response in N with the pre-clear data.
- Reset values:
  - All ready outputs 0.
  - rsp_valid 0.
  - rf_read_en and rf_write_en 0.
  - rf_reset 1 while reset is high; the register file is cleared.
  - rr pointer 0, streak counter 0, response valid 0.
- Reset during an outstanding read: the response is dropped and rsp_valid is 0 in the following cycle.
- Simultaneous clear, write and read: clear wins. The others stall with ready 0 and the streak counter unchanged.
- Counter saturation: the counter never exceeds WR_STREAK_MAX.

## Structure
- Package regfile_arb_pkg:
  - REG_ADDR_W=5, XLEN=32.
  - Enum grant_t {GNT_NONE, GNT_CLR, GNT_WR, GNT_RD}.
- Sub-module rr_arbiter, parameter N:
  - Inputs: req[N], advance, pointer.
  - Outputs: one-hot gnt, plus the index.
- Top level holds the priority logic, streak counter and response register.

## Test plan
- Reset: hold reset 2 cycles → rf_reset=1, all ready 0, rsp_valid 0. Then read x5 → rsp_data1=0.
- Write then read: write x3=0xDEADBEEF in N, client 0 reads rs1=3, rs2=0 in N+1 → rsp_valid=01 in N+2, data1=0xDEADBEEF, data2=0.
- Round-robin: both clients request continuously for 4 cycles → grants alternate 0,1,0,1, and responses follow one cycle later with matching ids.
- Starvation bound: wr_valid held high with client 1 reading continuously → writes granted for 4 cycles, then 1 read, then writes again.
- x0 write: wr_rd=0, wr_data=0x1234 → wr_ready=1, rf_write_en=0. A later read of x0 returns 0.
- Clear collision: clr_valid, wr_valid and rd_req_valid all asserted with x7=0x55 → clear granted first, then write, then read. A read of x7 after the clear and before the write returns 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file port arbiter.
//   REG_ADDR_W : register address width (32 registers)
//   XLEN       : register data width
//   grant_t    : which single operation owns the register-file port this cycle
package regfile_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CLR  = 2'd1,
        GNT_WR   = 2'd2,
        GNT_RD   = 2'd3
    } grant_t;

    // x0 is hardwired to zero: never written, always read as zero
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_port_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req     : request vector
//   i_advance : grant enable; o_gnt is all-zero when low
//   i_ptr     : highest-priority index this cycle (held by the parent)
//   o_gnt     : one-hot grant
//   o_idx     : index of the winner (valid when o_any)
//   o_any     : at least one request is present
module rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic             i_advance,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic        w_found;
    int unsigned w_cand;

    // Scan from the pointer upward, wrapping; first requester wins
    always_comb begin
        w_found = 1'b0;
        w_cand  = 0;
        o_idx   = '0;
        o_gnt   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = (32'(i_ptr) + k) % N;
            if (!w_found && i_req[IDX_W'(w_cand)]) begin
                w_found = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
        if (w_found && i_advance) begin
            o_gnt[o_idx] = 1'b1;
        end
        o_any = w_found;
    end

endmodule

// File: rtl/regfile_port_arb.sv
// Shares the single register-file port between NUM_RD read clients, one
// writeback client and clear-all requests. One operation per cycle:
// clear > (write vs read by streak rule) > idle. Read data returns one cycle
// after the grant, tagged to the granted client.
//   clk, reset                : clock, synchronous active-high reset
//   rd_req_valid/ready        : per-client read handshake (ready one-hot)
//   rd_rs1, rd_rs2            : flattened 5-bit source addresses per client
//   rsp_valid, rsp_data1/2    : one-hot response strobe and shared read data
//   wr_valid/ready, wr_rd/data: writeback handshake, address and data
//   clr_valid/ready           : clear-all handshake
//   rf_*                      : register-file control, address and data
module regfile_port_arb
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_RD        = 2,
    parameter int unsigned WR_STREAK_MAX = 4
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [NUM_RD-1:0]            rd_req_valid,
    output logic [NUM_RD-1:0]            rd_req_ready,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rd_rs1,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rd_rs2,
    output logic [NUM_RD-1:0]            rsp_valid,
    output logic [XLEN-1:0]              rsp_data1,
    output logic [XLEN-1:0]              rsp_data2,

    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [REG_ADDR_W-1:0]        wr_rd,
    input  logic [XLEN-1:0]              wr_data,

    input  logic                         clr_valid,
    output logic                         clr_ready,

    output logic                         rf_en,
    output logic                         rf_reset,
    output logic                         rf_read_en,
    output logic                         rf_write_en,
    output logic [REG_ADDR_W-1:0]        rf_rs1,
    output logic [REG_ADDR_W-1:0]        rf_rs2,
    output logic [REG_ADDR_W-1:0]        rf_rd,
    output logic [XLEN-1:0]              rf_data_in,
    input  logic [XLEN-1:0]              rf_out1,
    input  logic [XLEN-1:0]              rf_out2
);

    localparam int unsigned IDX_W    = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned STREAK_W = (WR_STREAK_MAX > 0) ? $clog2(WR_STREAK_MAX + 1) : 1;

    logic [IDX_W-1:0]      r_rr_ptr;
    logic [STREAK_W-1:0]   r_streak;
    logic                  r_rsp_valid;
    logic [IDX_W-1:0]      r_rsp_id;
    logic                  r_rsp_z1;
    logic                  r_rsp_z2;

    grant_t                w_gnt;
    logic                  w_rd_any;
    logic                  w_streak_full;
    logic [NUM_RD-1:0]     w_rd_gnt_vec;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [STREAK_W-1:0]   w_streak_nxt;

    rr_arbiter #(
        .N     (NUM_RD),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req     (rd_req_valid),
        .i_advance (w_gnt == GNT_RD),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_rd_gnt_vec),
        .o_idx     (w_rd_idx),
        .o_any     (w_rd_any)
    );

    assign w_rs1         = rd_rs1[REG_ADDR_W*32'(w_rd_idx) +: REG_ADDR_W];
    assign w_rs2         = rd_rs2[REG_ADDR_W*32'(w_rd_idx) +: REG_ADDR_W];
    assign w_streak_full = (r_streak == STREAK_W'(WR_STREAK_MAX));

    // Port ownership; nothing is granted while in reset
    always_comb begin
        w_gnt = GNT_NONE;
        if (reset) begin
            w_gnt = GNT_NONE;
        end else if (clr_valid) begin
            w_gnt = GNT_CLR;
        end else if (wr_valid && !(w_rd_any && w_streak_full)) begin
            w_gnt = GNT_WR;
        end else if (w_rd_any) begin
            w_gnt = GNT_RD;
        end
    end

    // Pointer moves past the winner only on a read grant
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_gnt == GNT_RD) begin
            w_ptr_nxt = (w_rd_idx == IDX_W'(NUM_RD - 1)) ? '0 : w_rd_idx + IDX_W'(1);
        end
    end

    // Write streak: counts writes that bypass pending reads; frozen on clear
    always_comb begin
        w_streak_nxt = r_streak;
        case (w_gnt)
            GNT_CLR: w_streak_nxt = r_streak;
            GNT_RD:  w_streak_nxt = '0;
            GNT_WR: begin
                if (!w_rd_any) begin
                    w_streak_nxt = '0;
                end else if (!w_streak_full) begin
                    w_streak_nxt = r_streak + STREAK_W'(1);
                end
            end
            default: begin
                if (!w_rd_any) begin
                    w_streak_nxt = '0;
                end
            end
        endcase
    end

    // Grant and register-file command outputs
    always_comb begin
        rd_req_ready = w_rd_gnt_vec;
        wr_ready     = (w_gnt == GNT_WR);
        clr_ready    = (w_gnt == GNT_CLR);
        rf_en        = 1'b1;
        rf_reset     = reset || (w_gnt == GNT_CLR);
        rf_read_en   = (w_gnt == GNT_RD);
        rf_write_en  = (w_gnt == GNT_WR) && !is_x0(wr_rd);
        rf_rs1       = (w_gnt == GNT_RD) ? w_rs1 : '0;
        rf_rs2       = (w_gnt == GNT_RD) ? w_rs2 : '0;
        rf_rd        = (w_gnt == GNT_WR) ? wr_rd : '0;
        rf_data_in   = (w_gnt == GNT_WR) ? wr_data : '0;
    end

    // Response steering; x0 operands read as zero
    always_comb begin
        rsp_valid = '0;
        if (r_rsp_valid) begin
            rsp_valid[r_rsp_id] = 1'b1;
        end
        rsp_data1 = r_rsp_z1 ? '0 : rf_out1;
        rsp_data2 = r_rsp_z2 ? '0 : rf_out2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_streak    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_z1    <= 1'b0;
            r_rsp_z2    <= 1'b0;
        end else begin
            r_rr_ptr    <= w_ptr_nxt;
            r_streak    <= w_streak_nxt;
            r_rsp_valid <= (w_gnt == GNT_RD);
            r_rsp_id    <= w_rd_idx;
            r_rsp_z1    <= is_x0(w_rs1);
            r_rsp_z2    <= is_x0(w_rs2);
        end
    end

endmodule

// File: tb/tb_regfile_port_arb.sv
// Directed bench for regfile_port_arb with a behavioural 32x32 register file.
module tb_regfile_port_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_req_valid;
    logic [1:0]  rd_req_ready;
    logic [9:0]  rd_rs1;
    logic [9:0]  rd_rs2;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic        clr_valid;
    logic        clr_ready;
    logic        rf_en;
    logic        rf_reset;
    logic        rf_read_en;
    logic        rf_write_en;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data_in;
    logic [31:0] rf_out1 = 32'h0;
    logic [31:0] rf_out2 = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_port_arb #(.NUM_RD(2), .WR_STREAK_MAX(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rs1       (rd_rs1),
        .rd_rs2       (rd_rs2),
        .rsp_valid    (rsp_valid),
        .rsp_data1    (rsp_data1),
        .rsp_data2    (rsp_data2),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_rd        (wr_rd),
        .wr_data      (wr_data),
        .clr_valid    (clr_valid),
        .clr_ready    (clr_ready),
        .rf_en        (rf_en),
        .rf_reset     (rf_reset),
        .rf_read_en   (rf_read_en),
        .rf_write_en  (rf_write_en),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rd        (rf_rd),
        .rf_data_in   (rf_data_in),
        .rf_out1      (rf_out1),
        .rf_out2      (rf_out2)
    );

    // Register file: registered reads, write at clock edge, synchronous clear
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rf_reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (rf_en && rf_write_en) begin
            mem[rf_rd] <= rf_data_in;
        end
        if (rf_en && rf_read_en) begin
            rf_out1 <= mem[rf_rs1];
            rf_out2 <= mem[rf_rs2];
        end
    end

    typedef struct {
        logic        clr;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [1:0]  rv;
        logic [9:0]  rs1;
        logic [9:0]  rs2;
        logic [1:0]  e_rdy;
        logic        e_wr;
        logic        e_clr;
        logic        e_ren;
        logic        e_wen;
        logic        e_rst;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [4:0]  e_rd;
        logic [31:0] e_din;
        logic [1:0]  e_rsp;
        logic        e_dchk;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic wv, input logic [4:0] wrd,
                         input logic [31:0] wdata, input logic [1:0] rv,
                         input logic [9:0] rs1, input logic [9:0] rs2);
        clr_valid    = clr;
        wr_valid     = wv;
        wr_rd        = wrd;
        wr_data      = wdata;
        rd_req_valid = rv;
        rd_rs1       = rs1;
        rd_rs2       = rs2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.clr, v.wv, v.wrd, v.wdata, v.rv, v.rs1, v.rs2);
        @(negedge clk);
        chk($sformatf("v%0d rd_req_ready", idx), 32'(rd_req_ready), 32'(v.e_rdy));
        chk($sformatf("v%0d wr_ready", idx),     32'(wr_ready),     32'(v.e_wr));
        chk($sformatf("v%0d clr_ready", idx),    32'(clr_ready),    32'(v.e_clr));
        chk($sformatf("v%0d rf_read_en", idx),   32'(rf_read_en),   32'(v.e_ren));
        chk($sformatf("v%0d rf_write_en", idx),  32'(rf_write_en),  32'(v.e_wen));
        chk($sformatf("v%0d rf_reset", idx),     32'(rf_reset),     32'(v.e_rst));
        chk($sformatf("v%0d rf_en", idx),        32'(rf_en),        32'h1);
        chk($sformatf("v%0d rsp_valid", idx),    32'(rsp_valid),    32'(v.e_rsp));
        if (v.e_ren) begin
            chk($sformatf("v%0d rf_rs1", idx), 32'(rf_rs1), 32'(v.e_rs1));
            chk($sformatf("v%0d rf_rs2", idx), 32'(rf_rs2), 32'(v.e_rs2));
        end
        if (v.e_wr) begin
            chk($sformatf("v%0d rf_rd", idx),      32'(rf_rd), 32'(v.e_rd));
            chk($sformatf("v%0d rf_data_in", idx), rf_data_in, v.e_din);
        end
        if (v.e_dchk) begin
            chk($sformatf("v%0d rsp_data1", idx), rsp_data1, v.e_d1);
            chk($sformatf("v%0d rsp_data2", idx), rsp_data2, v.e_d2);
        end
        next_cycle();
    endtask

    initial begin
        // clr wv wrd wdata rv rs1 rs2 | rdy wr clr ren wen rst rs1 rs2 rd din rsp dchk d1 d2
        vecs[0]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b01, {5'd0, 5'd5}, {5'd0, 5'd5},
                     2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b01, 1'b1, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b01, {5'd0, 5'd3}, {5'd0, 5'd0},
                     2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b11, {5'd0, 5'd3}, {5'd3, 5'd3},
                     2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 2'b01, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b11, {5'd0, 5'd3}, {5'd3, 5'd3},
                     2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0, 2'b10, 1'b1, 32'h0, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b11, {5'd0, 5'd3}, {5'd3, 5'd3},
                     2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0, 2'b01, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b11, {5'd0, 5'd3}, {5'd3, 5'd3},
                     2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0, 2'b10, 1'b1, 32'h0, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b01, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[10] = '{1'b0, 1'b1, 5'd0, 32'h1234, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h1234, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b01, 10'd0, 10'd0,
                     2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b01, 1'b1, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 5'd3, 32'h1, 2'b01, {5'd0, 5'd3}, {5'd0, 5'd3},
                     2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0,
                     2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0};

        // Reset held two cycles with every request asserted
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd4, 32'hFFFF, 2'b11, {5'd1, 5'd2}, {5'd3, 5'd4});
        @(posedge clk);
        next_cycle();
        @(negedge clk);
        chk("reset rf_reset",     32'(rf_reset),     32'h1);
        chk("reset rd_req_ready", 32'(rd_req_ready), 32'h0);
        chk("reset wr_ready",     32'(wr_ready),     32'h0);
        chk("reset clr_ready",    32'(clr_ready),    32'h0);
        chk("reset rsp_valid",    32'(rsp_valid),    32'h0);
        chk("reset rf_read_en",   32'(rf_read_en),   32'h0);
        chk("reset rf_write_en",  32'(rf_write_en),  32'h0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Write streak bound: client 1 reads x9 continuously under write pressure
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 5'd9, 32'h100 + 32'(k), 2'b10, {5'd9, 5'd0}, {5'd9, 5'd0});
            @(negedge clk);
            chk($sformatf("streak c%0d wr_ready", k), 32'(wr_ready),
                (k == 4 || k == 9) ? 32'h0 : 32'h1);
            chk($sformatf("streak c%0d rd_req_ready", k), 32'(rd_req_ready),
                (k == 4 || k == 9) ? 32'h2 : 32'h0);
            if (k == 5) begin
                chk("streak rsp_valid", 32'(rsp_valid), 32'h2);
                chk("streak rsp_data1", rsp_data1, 32'h103);
            end
            next_cycle();
        end
        idle();
        next_cycle();

        // Clear/write/read collision on x7
        drive(1'b0, 1'b1, 5'd7, 32'h55, 2'b00, 10'd0, 10'd0);
        next_cycle();
        drive(1'b1, 1'b1, 5'd7, 32'hAA, 2'b01, {5'd0, 5'd7}, {5'd0, 5'd7});
        @(negedge clk);
        chk("coll clr_ready",    32'(clr_ready),    32'h1);
        chk("coll wr_ready",     32'(wr_ready),     32'h0);
        chk("coll rd_req_ready", 32'(rd_req_ready), 32'h0);
        next_cycle();
        clr_valid = 1'b0;
        @(negedge clk);
        chk("coll2 wr_ready",     32'(wr_ready),     32'h1);
        chk("coll2 rd_req_ready", 32'(rd_req_ready), 32'h0);
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("coll3 rd_req_ready", 32'(rd_req_ready), 32'h1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("coll rsp_valid", 32'(rsp_valid), 32'h1);
        chk("coll rsp_data1", rsp_data1, 32'hAA);
        next_cycle();

        // Read before clear sees old data; read after clear sees zero
        drive(1'b0, 1'b1, 5'd7, 32'h55, 2'b00, 10'd0, 10'd0);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b01, {5'd0, 5'd7}, {5'd0, 5'd7});
        @(negedge clk);
        chk("preclr rd_req_ready", 32'(rd_req_ready), 32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 2'b00, 10'd0, 10'd0);
        @(negedge clk);
        chk("preclr rsp_valid", 32'(rsp_valid), 32'h1);
        chk("preclr rsp_data1", rsp_data1, 32'h55);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b01, {5'd0, 5'd7}, {5'd0, 5'd7});
        next_cycle();
        idle();
        @(negedge clk);
        chk("postclr rsp_valid", 32'(rsp_valid), 32'h1);
        chk("postclr rsp_data1", rsp_data1, 32'h0);
        next_cycle();

        // Reset while a read response is outstanding
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b10, {5'd7, 5'd0}, {5'd7, 5'd0});
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("rstrd rd_req_ready", 32'(rd_req_ready), 32'h0);
        chk("rstrd rf_reset",     32'(rf_reset),     32'h1);
        next_cycle();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rstrd rsp_valid", 32'(rsp_valid), 32'h0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
